// File: rtl/epsilon_greedy_selector.sv
// rtl/epsilon_greedy_selector.sv - epsilon-greedy action selector over a 4-entry signed Q row
// Fixed 4-cycle decision latency; exploration draws from a free-running 16-bit Fibonacci LFSR.
module epsilon_greedy_selector #(
  parameter int          NUM_ACT   = 4,
  parameter int          Q_W       = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_ACT*Q_W-1:0]   q_row,
  input  logic [7:0]               epsilon,
  output logic [3:0]               action,
  output logic                     valid,
  output logic                     explore,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state;
  logic [15:0]                 lfsr;
  logic                        lfsr_fb;
  logic [9:0]                  rnd;
  logic [(NUM_ACT-1)*Q_W-1:0]  q_hi;
  logic [7:0]                  eps_lat;
  logic [1:0]                  idx;
  logic [1:0]                  best_idx;
  logic signed [Q_W-1:0]       best;
  logic signed [Q_W-1:0]       q_cur;
  logic [1:0]                  act_r;
  int unsigned                 q_base;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign action  = {2'b00, act_r};

  // q0 seeds best directly, so only entries 1..3 are kept; idx selects entry idx+1
  always_comb begin
    q_base = 32'(idx) * 32'(Q_W);
    q_cur  = q_hi[q_base +: Q_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      state    <= S_IDLE;
      rnd      <= '0;
      q_hi     <= '0;
      eps_lat  <= '0;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      act_r    <= '0;
      valid    <= 1'b0;
      explore  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      lfsr  <= (lfsr == 16'h0000) ? LFSR_SEED : {lfsr[14:0], lfsr_fb};
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            q_hi     <= q_row[NUM_ACT*Q_W-1:Q_W];
            eps_lat  <= epsilon;
            rnd      <= lfsr[9:0];
            idx      <= '0;
            best     <= q_row[Q_W-1:0];
            best_idx <= '0;
            busy     <= 1'b1;
            state    <= S_SCAN;
          end else begin
            busy <= 1'b0;
          end
        end
        S_SCAN: begin
          // strict greater-than keeps the lowest index on ties
          if (q_cur > best) begin
            best     <= q_cur;
            best_idx <= idx + 2'd1;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd2) state <= S_DONE;
        end
        S_DONE: begin
          valid <= 1'b1;
          if (rnd[7:0] < eps_lat) begin
            act_r   <= rnd[9:8];
            explore <= 1'b1;
          end else begin
            act_r   <= best_idx;
            explore <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
// tb/tb_epsilon_greedy_selector.sv - self-checking bench for epsilon_greedy_selector
// Reference model tracks decisions by cycle number and is compared against the DUT every cycle.
module tb_epsilon_greedy_selector;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] q_row = '0;
  logic [7:0]  epsilon = '0;
  logic [3:0]  action;
  logic        valid;
  logic        explore;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  epsilon_greedy_selector #(.NUM_ACT(4), .Q_W(16), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_row(q_row), .epsilon(epsilon),
    .action(action), .valid(valid), .explore(explore), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v == 16'h0000) return SEED;
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // first index whose value equals the row maximum
  function automatic logic [1:0] greedy_pick(input logic [63:0] r);
    int vals[4];
    int mx;
    for (int i = 0; i < 4; i++) vals[i] = int'($signed(r[16*i +: 16]));
    mx = vals[0];
    for (int i = 1; i < 4; i++) if (vals[i] > mx) mx = vals[i];
    for (int i = 0; i < 4; i++) if (vals[i] == mx) return 2'(i);
    return 2'd0;
  endfunction

  logic [15:0] m_lfsr = SEED;
  int          cyc = 0;
  int          busy_until = -1;
  int          due = 0;
  bit          m_pend = 0;
  bit          m_valid = 0;
  logic [1:0]  m_act = '0;
  bit          m_exp = 0;
  logic [1:0]  m_act_q = '0;
  bit          m_exp_q = 0;
  bit          seen [4] = '{0, 0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = SEED;
      busy_until = -1;
      m_pend = 0;
      m_valid = 0;
      m_act_q = '0;
      m_exp_q = 0;
    end else begin
      cyc++;
      m_valid = 0;
      if (m_pend && cyc == due) begin
        m_valid = 1;
        m_act_q = m_act;
        m_exp_q = m_exp;
        m_pend = 0;
      end
      if (start && cyc > busy_until) begin
        m_exp = (m_lfsr[7:0] < epsilon);
        m_act = m_exp ? m_lfsr[9:8] : greedy_pick(q_row);
        if (m_exp) seen[m_act] = 1;
        due = cyc + 4;
        busy_until = cyc + 4;
        m_pend = 1;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(cyc <= busy_until));
      check("action", 32'(action), {30'd0, m_act_q});
      check("explore", 32'(explore), 32'(m_exp_q));
    end
  end

  task automatic do_start(input logic [63:0] q, input logic [7:0] e);
    q_row = q;
    epsilon = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q_row = ~q;
    epsilon = ~e;
  endtask

  task automatic wait_valid(input string name, input logic [3:0] want_a, input logic want_e);
    bit got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (valid) begin
        got = 1;
        check({name, "_action"}, 32'(action), 32'(want_a));
        check({name, "_explore"}, 32'(explore), 32'(want_e));
      end
    end
    if (!got) check({name, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_any();
    bit got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (valid) got = 1;
    end
    if (!got) check("loop_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_action"}, 32'(action), 32'd0);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_explore"}, 32'(explore), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("model_lfsr_step1", 32'(m_lfsr), 32'h59C3);
    @(negedge clk);
    do_start({$urandom, $urandom}, 8'hFF);
    check("model_lfsr_step2", 32'(m_lfsr), 32'hB387);
    wait_valid("por_explore", 4'd1, 1'b1);

    do_start({16'h0010, 16'h7FFF, 16'h8000, 16'h0005}, 8'd0);
    wait_valid("mixed", 4'd2, 1'b0);
    do_start({16'hFFFD, 16'hFF9C, 16'hFFFE, 16'hFFFB}, 8'd0);
    wait_valid("all_neg", 4'd1, 1'b0);
    do_start({4{16'h0100}}, 8'd0);
    wait_valid("tie_all", 4'd0, 1'b0);
    do_start({16'h0200, 16'h0200, 16'h0100, 16'h0100}, 8'd0);
    wait_valid("tie_hi", 4'd2, 1'b0);

    do_start({16'hFFFD, 16'hFF9C, 16'hFFFE, 16'hFFFB}, 8'd0);
    @(negedge clk);
    do_start({16'h0010, 16'h7FFF, 16'h8000, 16'h0005}, 8'd0);
    wait_valid("busy_reject", 4'd1, 1'b0);
    do_start({16'h0200, 16'h0200, 16'h0100, 16'h0100}, 8'd0);
    wait_valid("accept_e5", 4'd2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_start({$urandom, $urandom}, 8'($urandom_range(0, 255)));
      wait_any();
    end

    do_start({16'h0010, 16'h7FFF, 16'h8000, 16'h0005}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start({$urandom, $urandom}, 8'hFF);
    wait_valid("post_rst_explore", 4'd1, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      do_start({$urandom, $urandom}, 8'hFF);
      wait_any();
    end
    check("explore_all_actions", {28'd0, 4'(seen[3]), 4'(seen[2])} << 0 == 0 ? 32'd0 :
          {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'hF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
